// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared encodings for the MA-stage data-memory path: responder FSM states,
// MEM_READ / MEM_WRITE type codes and enable-bit positions. The control unit
// uses the same codes, so any change here affects the decoder as well.
// Optional feature macro used by importers: DMEM_MISALIGN_CHECK_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    // Enable bit positions inside MEM_READ[3:0] / MEM_WRITE[2:0]
    localparam int RD_EN_BIT = 3;
    localparam int WR_EN_BIT = 2;

    // MEM_READ[2:0] (funct3) load codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // MEM_WRITE[1:0] store codes
    localparam logic [1:0] WT_SB = 2'b00;
    localparam logic [1:0] WT_SH = 2'b01;
    localparam logic [1:0] WT_SW = 2'b10;

    // Halfword access with odd address, or word access not on a 4-byte
    // boundary. A write takes precedence over a read when both are enabled.
    function automatic logic is_misaligned(
        input logic       wr_en,
        input logic [1:0] wtype,
        input logic [2:0] funct3,
        input logic [1:0] offset
    );
        logic half;
        logic word;
        if (wr_en) begin
            half = (wtype == WT_SH);
            word = (wtype == WT_SW);
        end else begin
            half = (funct3 == F3_LH) || (funct3 == F3_LHU);
            word = (funct3 == F3_LW);
        end
        return (half && offset[0]) || (word && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align
// Combinational load formatter: picks the addressed byte/halfword out of a
// 32-bit memory word, shifts it to bit 0 and sign- or zero-extends it.
// Undefined funct3 codes produce 0.
// Ports:
//   i_word    32  raw memory word
//   i_offset   2  byte offset (address bits [1:0])
//   i_funct3   3  load type (LB/LH/LW/LBU/LHU)
//   o_data    32  extended load result
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[8*i_offset +: 8];
        // Halfword lane chosen by offset[1] only; offset[0] is ignored here
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data = i_word;
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Fixed-latency data-memory responder for the MA stage. Accepts a load/store
// request, stalls the core with BUSYWAIT for LATENCY cycles, performs the
// access into an internal word array and presents the load result in the
// DONE cycle.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned
// half/word accesses (write suppressed, READ_DATA=0, ERR=1 in DONE).
// Ports:
//   CLK         1   clock, rising edge
//   RST         1   synchronous active-low reset
//   ADDR       32   byte address (upper bits above ADDR_WIDTH+1 wrap)
//   WRITE_DATA 32   store data, LSB-aligned
//   MEM_READ    4   {rd_en, funct3}
//   MEM_WRITE   3   {wr_en, store type}
//   READ_DATA  32   extended load result (held until next load / reset)
//   BUSYWAIT    1   stall request to the core
//   ERR         1   misaligned-access flag
//
// FSM states:
//   state | meaning
//   IDLE  | waiting; a request raises BUSYWAIT combinationally and is latched
//   BUSY  | counting down; access performed on the edge where counter is 1
//   DONE  | BUSYWAIT low, result valid; always returns to IDLE
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  MEM_READ,
    input  logic [2:0]  MEM_WRITE,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        ERR
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_t r_state;
    dmem_state_t w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_busy;
    logic        w_perform;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_rd;
    logic [2:0]  r_wr;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [2**ADDR_WIDTH];

    logic        w_req;
    logic        w_accept;
    logic [31:0] w_a_addr;
    logic [31:0] w_a_data;
    logic [3:0]  w_a_rd;
    logic [2:0]  w_a_wr;
    logic [ADDR_WIDTH-1:0] w_a_idx;
    logic [1:0]  w_a_off;
    logic        w_a_wr_en;
    logic        w_a_rd_en;
    logic        w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_mask;
    logic [31:0] w_rword;
    logic [31:0] w_load;
    logic        w_mem_we;
    logic        w_unused;

    assign w_req    = MEM_READ[RD_EN_BIT] | MEM_WRITE[WR_EN_BIT];
    assign w_accept = (r_state == ST_IDLE) && w_req;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_busy     = 1'b0;
        w_perform  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_busy     = 1'b1;
                    w_cnt_next = CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_perform = 1'b1;
                        w_next    = ST_DONE;
                    end else begin
                        w_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_busy     = 1'b1;
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_perform = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign BUSYWAIT = w_busy;

    // ---------------- Request latch ----------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rd    <= 4'd0;
            r_wr    <= 3'd0;
        end else if (w_accept) begin
            r_addr  <= ADDR;
            r_wdata <= WRITE_DATA;
            r_rd    <= MEM_READ;
            r_wr    <= MEM_WRITE;
        end
    end

    // With LATENCY=1 the access happens on the accept edge, so IDLE uses the
    // live inputs; every other state uses the latched copy.
    assign w_a_addr  = (r_state == ST_IDLE) ? ADDR       : r_addr;
    assign w_a_data  = (r_state == ST_IDLE) ? WRITE_DATA : r_wdata;
    assign w_a_rd    = (r_state == ST_IDLE) ? MEM_READ   : r_rd;
    assign w_a_wr    = (r_state == ST_IDLE) ? MEM_WRITE  : r_wr;
    assign w_a_idx   = w_a_addr[ADDR_WIDTH+1:2];
    assign w_a_off   = w_a_addr[1:0];
    assign w_a_wr_en = w_a_wr[WR_EN_BIT];
    assign w_a_rd_en = w_a_rd[RD_EN_BIT] & ~w_a_wr_en;
    assign w_unused  = &{1'b0, w_a_addr[31:ADDR_WIDTH+2]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_mis = is_misaligned(w_a_wr_en, w_a_wr[1:0], w_a_rd[2:0], w_a_off);
`else
    assign w_mis = 1'b0;
`endif

    // ---------------- Store path ----------------
    always_comb begin
        w_be = 4'b0000;
        w_wd = w_a_data;
        case (w_a_wr[1:0])
            WT_SB: begin
                w_be = 4'b0001 << w_a_off;
                w_wd = {4{w_a_data[7:0]}};
            end
            WT_SH: begin
                w_be = w_a_off[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{w_a_data[15:0]}};
            end
            WT_SW: begin
                w_be = 4'b1111;
            end
            default: begin
                w_be = 4'b0000;
            end
        endcase
    end

    assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_rword  = r_mem[w_a_idx];
    // Reset has priority: an access due on a reset edge is dropped.
    assign w_mem_we = RST & w_perform & w_a_wr_en & ~w_mis;

    // Array is intentionally not reset.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_a_idx] <= (w_rword & ~w_mask) | (w_wd & w_mask);
        end
    end

    // ---------------- Load path ----------------
    dmem_load_align u_load_align (
        .i_word   (w_rword),
        .i_offset (w_a_off),
        .i_funct3 (w_a_rd[2:0]),
        .o_data   (w_load)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            // Only ever set on the edge entering DONE, so ERR lasts one cycle
            r_err <= w_perform & w_mis;
            if (w_perform) begin
                if (w_mis) begin
                    r_rdata <= 32'd0;
                end else if (w_a_rd_en) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign READ_DATA = r_rdata;
    assign ERR       = r_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32IM pipeline's MA stage.
- Consumes the core's data-memory request (address, write data, encoded read/write type) and holds the pipeline with BUSYWAIT for a fixed access latency.
- Performs byte/half/word stores into an internal word array.
- Returns loads with RV32 sign/zero extension, ready for the MA/WB register.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2**ADDR_WIDTH words.
- LATENCY, 3, number of cycles BUSYWAIT is high per access; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-low reset.
- ADDR  in  32  byte address; bits [1:0] select byte lane; bits [ADDR_WIDTH+1:2] index the array; upper bits ignored (wrap).
- WRITE_DATA  in  32  store data, LSB-aligned.
- MEM_READ  in  4  bit3 = read enable; bits[2:0] = funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- MEM_WRITE  in  3  bit2 = write enable; bits[1:0]: 00 SB, 01 SH, 10 SW.
- READ_DATA  out  32  extended load result.
- BUSYWAIT  out  1  stall request to the core.
- ERR  out  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (RST=0 at an edge):
  - State goes to IDLE; counter = 0.
  - READ_DATA = 0, ERR = 0; BUSYWAIT = 0 from the following cycle.
  - Array contents are not cleared.
  - A reset mid-access aborts the access: a pending write is not performed and READ_DATA is not updated.
- Request definition: request = MEM_READ[3] | MEM_WRITE[2].
  - If both are set, the write is performed and READ_DATA is unchanged.
- State machine: IDLE, BUSY, DONE.
  - IDLE, no request: BUSYWAIT = 0.
  - IDLE, with request: BUSYWAIT = 1 combinationally in the same cycle.
    - Request fields (addr, data, type) are latched at this edge.
    - Counter loads LATENCY-1.
    - Next state is BUSY, or DONE directly if LATENCY = 1; for LATENCY = 1 the access is performed at this edge.
  - BUSY: BUSYWAIT = 1; counter decrements each edge.
    - At the edge where the counter is 1, the access is performed and state goes to DONE.
    - Input changes during BUSY are ignored; the latched request is used.
  - DONE: BUSYWAIT = 0; READ_DATA holds the result.
    - The core advances its pipeline at this edge.
    - Unconditional transition to IDLE; the still-present request is not re-accepted.
  - Net timing: BUSYWAIT is high for exactly LATENCY consecutive cycles.
    - Result is valid in the DONE cycle.
    - Back-to-back requests cost LATENCY+1 cycles each, including the DONE cycle.
- Store rules:
  - SB writes byte lane ADDR[1:0] with WRITE_DATA[7:0].
  - SH writes lanes {ADDR[1],0} and {ADDR[1],1} with WRITE_DATA[15:0].
  - SW writes the full word.
  - Other bytes are untouched.
- Load rules:
  - The selected lane(s) are shifted to bit 0.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Loads with an undefined funct3 (011, 110, 111) return 0.
- Stores with type 11 write nothing.
- READ_DATA holds its value until the next completed load or a reset.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Enabled:
  - At the accept cycle, a halfword access with ADDR[0]=1 or a word access with ADDR[1:0]≠00 is flagged.
  - The flagged access still takes LATENCY cycles.
  - Its write is suppressed and READ_DATA is set to 0.
  - ERR = 1 during its DONE cycle only.
- Disabled:
  - ERR tied 0.
  - Halfword accesses use ADDR[1]; ADDR[0] is ignored.
  - Word accesses ignore ADDR[1:0].

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state encoding (IDLE/BUSY/DONE).
  - MEM_READ codes: LB, LH, LW, LBU, LHU.
  - MEM_WRITE codes: SB, SH, SW.
  - Read/write enable bit positions.
- The same codes are reused by the control unit.
- One natural sub-module: dmem_load_align.
  - Combinational lane select plus sign/zero extension from {word, addr[1:0], funct3} to 32 bits.
  - Reusable by a future data cache.

Test Plan (LATENCY=3):
- Reset then idle.
  - Stimulus: RST=0 for 2 cycles, then no request.
  - Required: READ_DATA=0, BUSYWAIT=0, ERR=0.
- SW then LW.
  - Stimulus: SW addr 0x10, data 0xDEADBEEF; then LW 0x10.
  - Required: each access gives BUSYWAIT=1 for exactly 3 cycles, then a DONE cycle with BUSYWAIT=0.
  - Required: READ_DATA=0xDEADBEEF in the LW DONE cycle.
- Byte/half extension.
  - Stimulus: after the store, LB 0x13, LBU 0x13, LH 0x12, LHU 0x10.
  - Required: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- Partial store.
  - Stimulus: SB 0x11 data 0x12345678; then LW 0x10.
  - Required: 0xDEAD78EF.
- Input hold.
  - Stimulus: change ADDR to 0x20 mid-BUSY of a LW 0x10.
  - Required: result is still from 0x10.
  - Required: in the DONE cycle, the request is not re-accepted.
- Reset mid-access and misalignment.
  - Stimulus: RST=0 during BUSY of SW 0x10 data 0x0; then LW 0x10.
  - Required: LW returns 0xDEAD78EF.
  - Stimulus (with DMEM_MISALIGN_CHECK_EN): LW 0x11.
  - Required: ERR=1 in DONE, READ_DATA=0.
